// File: rtl/rr_pipe_scheduler_if.sv
// rtl/rr_pipe_scheduler_if.sv - request/data/stall inputs and grant/pipeline outputs of the scheduler
interface rr_pipe_scheduler_if #(
    parameter int DATA_W = 4
);
    logic [2:0]          req_i;
    logic [3*DATA_W-1:0] data_i;
    logic                stall_i;
    logic [2:0]          gnt_o;
    logic [DATA_W-1:0]   out_o1;
    logic [DATA_W-1:0]   out_o2;
    logic [DATA_W-1:0]   out_o3;
    logic [2:0]          vld_o;
    logic [1:0]          id_o;

    modport master (
        output req_i, data_i, stall_i,
        input  gnt_o, out_o1, out_o2, out_o3, vld_o, id_o
    );

    modport slave (
        input  req_i, data_i, stall_i,
        output gnt_o, out_o1, out_o2, out_o3, vld_o, id_o
    );
endinterface

// File: rtl/rr_pipe_scheduler.sv
// rtl/rr_pipe_scheduler.sv - 3-way round-robin burst arbiter feeding a 3-stage stallable pipeline
module rr_pipe_scheduler #(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    rr_pipe_scheduler_if.slave   bus
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [2:0] LP_LAST = 3'(MAX_BURST - 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_owner, w_owner_nxt;
    logic [1:0]        r_ptr,   w_ptr_nxt;
    logic [2:0]        r_cnt,   w_cnt_nxt;
    logic [2:0]        r_gnt,   w_gnt_nxt;

    logic [DATA_W-1:0] r_s1, r_s2, r_s3;
    logic [2:0]        r_vld;
    logic [1:0]        r_t1, r_t2, r_t3;

    logic              w_owner_req;
    logic              w_acc;
    logic              w_release;
    logic [1:0]        w_rearb_start;
    logic [DATA_W-1:0] w_sel_data;

    function automatic logic [1:0] f_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // First active requester scanning start, start+1, start+2 (mod 3).
    function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] start);
        logic [1:0] s1;
        logic [1:0] s2;
        s1 = f_inc(start);
        s2 = f_inc(s1);
        if (req[start])
            return start;
        else if (req[s1])
            return s1;
        else
            return s2;
    endfunction

    always_comb begin
        w_owner_req = 1'b0;
        w_sel_data  = '0;
        case (r_owner)
            2'd0: begin
                w_owner_req = bus.req_i[0];
                w_sel_data  = bus.data_i[0*DATA_W +: DATA_W];
            end
            2'd1: begin
                w_owner_req = bus.req_i[1];
                w_sel_data  = bus.data_i[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                w_owner_req = bus.req_i[2];
                w_sel_data  = bus.data_i[2*DATA_W +: DATA_W];
            end
            default: begin
                w_owner_req = 1'b0;
                w_sel_data  = '0;
            end
        endcase
    end

    assign w_acc         = (r_state == S_BUSY) && w_owner_req && !bus.stall_i;
    assign w_rearb_start = f_inc(r_owner);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 3'd0;
            r_gnt   <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // A dropped owner request releases even under stall; everything else waits for !stall.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.stall_i && (|bus.req_i)) begin
                    w_state_nxt = S_BUSY;
                    w_owner_nxt = f_pick(bus.req_i, r_ptr);
                    w_gnt_nxt   = 3'b001 << f_pick(bus.req_i, r_ptr);
                end
            end
            S_BUSY: begin
                if (!w_owner_req || (w_acc && (r_cnt == LP_LAST)))
                    w_release = 1'b1;
                else if (w_acc)
                    w_cnt_nxt = r_cnt + 3'd1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
            end
        endcase
        if (w_release) begin
            w_ptr_nxt = w_rearb_start;
            w_cnt_nxt = 3'd0;
            if (|bus.req_i) begin
                w_state_nxt = S_BUSY;
                w_owner_nxt = f_pick(bus.req_i, w_rearb_start);
                w_gnt_nxt   = 3'b001 << f_pick(bus.req_i, w_rearb_start);
            end else begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
            end
        end
    end

    // Bubbles carry tag 0, so stage-3 tag doubles as id_o without masking.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_s3  <= '0;
            r_vld <= 3'b000;
            r_t1  <= 2'd0;
            r_t2  <= 2'd0;
            r_t3  <= 2'd0;
        end else if (!bus.stall_i) begin
            r_s1  <= w_acc ? w_sel_data : '0;
            r_t1  <= w_acc ? r_owner : 2'd0;
            r_s2  <= r_s1;
            r_t2  <= r_t1;
            r_s3  <= r_s2;
            r_t3  <= r_t2;
            r_vld <= {r_vld[1:0], w_acc};
        end
    end

    assign bus.gnt_o  = r_gnt;
    assign bus.out_o1 = r_s1;
    assign bus.out_o2 = r_s2;
    assign bus.out_o3 = r_s3;
    assign bus.vld_o  = r_vld;
    assign bus.id_o   = r_t3;

endmodule

// File: tb/tb_rr_pipe_scheduler.sv
// tb/tb_rr_pipe_scheduler.sv - directed vector bench for rr_pipe_scheduler (DATA_W=4, MAX_BURST=2)
module tb_rr_pipe_scheduler;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [11:0] data;
        logic        stall;
        logic [2:0]  gnt;
        logic [2:0]  vld;
        logic [3:0]  o1;
        logic [3:0]  o2;
        logic [3:0]  o3;
        logic [1:0]  id;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    rr_pipe_scheduler_if #(.DATA_W(4)) bus ();

    rr_pipe_scheduler #(.DATA_W(4), .MAX_BURST(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] req, input logic [11:0] data,
                                input logic stall, input logic [2:0] gnt, input logic [2:0] vld,
                                input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] o3,
                                input logic [1:0] id);
        vec_t v;
        v.rst = r; v.req = req; v.data = data; v.stall = stall;
        v.gnt = gnt; v.vld = vld; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.id = id;
        return v;
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] act;
        act = {bus.gnt_o, bus.vld_o, bus.out_o1, bus.out_o2, bus.out_o3, bus.id_o};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: {gnt,vld,o1,o2,o3,id} got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst         = v.rst;
        bus.req_i   = v.req;
        bus.data_i  = v.data;
        bus.stall_i = v.stall;
        @(posedge clk);
        #1;
        check(name, {v.gnt, v.vld, v.o1, v.o2, v.o3, v.id});
    endtask

    localparam logic [11:0] D = 12'hCA5;

    initial begin
        bus.req_i   = 3'b000;
        bus.data_i  = D;
        bus.stall_i = 1'b0;

        // single requester, burst, release/regrant, drain
        tbl.push_back(mk(0, 3'b001, D, 0, 3'b001, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b001, D, 0, 3'b001, 3'b001, 4'h5, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b001, D, 0, 3'b001, 3'b011, 4'h5, 4'h5, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b110, 4'h0, 4'h5, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b100, 4'h0, 4'h0, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk(1, 3'b000, D, 0, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0));
        // round robin with all requesting
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b001, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b001, 3'b001, 4'h5, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b010, 3'b011, 4'h5, 4'h5, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b010, 3'b111, 4'hA, 4'h5, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b100, 3'b111, 4'hA, 4'hA, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b100, 3'b111, 4'hC, 4'hA, 4'hA, 2'd1));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b001, 3'b111, 4'hC, 4'hC, 4'hA, 2'd1));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b001, 3'b111, 4'h5, 4'hC, 4'hC, 2'd2));
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b010, 3'b111, 4'h5, 4'h5, 4'hC, 2'd2));
        // owner 1 drops after one beat while requester 2 waits
        tbl.push_back(mk(0, 3'b111, D, 0, 3'b010, 3'b111, 4'hA, 4'h5, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b101, D, 0, 3'b100, 3'b110, 4'h0, 4'hA, 4'h5, 2'd0));
        tbl.push_back(mk(0, 3'b100, D, 0, 3'b100, 3'b101, 4'hC, 4'h0, 4'hA, 2'd1));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b010, 4'h0, 4'hC, 4'h0, 2'd0));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b100, 4'h0, 4'h0, 4'hC, 2'd2));
        tbl.push_back(mk(0, 3'b000, D, 0, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 20'h0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // stall mid-burst: stage contents, grant and count frozen; data during stall ignored
        apply(mk(0, 3'b001, 12'hCA1, 0, 3'b001, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0), "stall_grant");
        apply(mk(0, 3'b001, 12'hCA1, 0, 3'b001, 3'b001, 4'h1, 4'h0, 4'h0, 2'd0), "stall_beat1");
        for (int k = 0; k < 3; k++)
            apply(mk(0, 3'b001, 12'hCA7, 1, 3'b001, 3'b001, 4'h1, 4'h0, 4'h0, 2'd0),
                  $sformatf("stall_hold%0d", k));
        apply(mk(0, 3'b001, 12'hCA2, 0, 3'b001, 3'b011, 4'h2, 4'h1, 4'h0, 2'd0), "stall_beat2");
        apply(mk(0, 3'b000, 12'hCA3, 0, 3'b000, 3'b110, 4'h0, 4'h2, 4'h1, 2'd0), "stall_drain1");
        apply(mk(0, 3'b000, 12'hCA3, 0, 3'b000, 3'b100, 4'h0, 4'h0, 4'h2, 2'd0), "stall_drain2");

        // fill all stages, then reset asynchronously between edges
        apply(mk(0, 3'b001, 12'hCA4, 0, 3'b001, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0), "fill0");
        apply(mk(0, 3'b001, 12'hCA4, 0, 3'b001, 3'b001, 4'h4, 4'h0, 4'h0, 2'd0), "fill1");
        apply(mk(0, 3'b001, 12'hCA4, 0, 3'b001, 3'b011, 4'h4, 4'h4, 4'h0, 2'd0), "fill2");
        apply(mk(0, 3'b001, 12'hCA4, 0, 3'b001, 3'b111, 4'h4, 4'h4, 4'h4, 2'd0), "fill3");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 20'h0);
        apply(mk(1, 3'b110, D, 0, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0), "reset_held");
        apply(mk(0, 3'b110, D, 0, 3'b010, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0), "post_reset_grant");
        // owner drops while stalled: release and regrant still happen, pipeline frozen
        apply(mk(0, 3'b100, D, 1, 3'b100, 3'b000, 4'h0, 4'h0, 4'h0, 2'd0), "drop_in_stall");
        apply(mk(0, 3'b100, D, 0, 3'b100, 3'b001, 4'hC, 4'h0, 4'h0, 2'd0), "after_stall_beat");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_pipe_scheduler.md
RR_PIPE_SCHEDULER -- requirements
Module: rr_pipe_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of each data beat and pipeline stage.
REQ-002 SHALL have parameter MAX_BURST, default 2, range 1..7, maximum beats accepted from one owner per grant.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_i  input  3  request, bit k from requester k.
REQ-006 SHALL have port data_i  input  3*DATA_W  packed beats; requester k at [k*DATA_W +: DATA_W].
REQ-007 SHALL have port stall_i  input  1  pipeline hold; 1 freezes all stages and blocks acceptance.
REQ-008 SHALL have port gnt_o  output  3  registered one-hot grant.
REQ-009 SHALL have ports out_o1, out_o2, out_o3  output  DATA_W each  stage 1, 2, 3 data.
REQ-010 SHALL have port vld_o  output  3  valid per stage; bit 0 = stage 1.
REQ-011 SHALL have port id_o  output  2  requester index of the stage-3 beat; 0 when vld_o[2]=0.

Function
REQ-012 SHALL accept a beat in a cycle iff gnt_o[k] & req_i[k] & !stall_i for owner k.
REQ-013 SHALL load an accepted beat into stage 1 at the next edge, with vld_o[0]=1 and tag k.
REQ-014 SHALL update all stages simultaneously from pre-edge values: stage2<=stage1, stage3<=stage2, tags and valids alongside.
REQ-015 SHALL load stage 1 with data 0, valid 0 on a non-stalled cycle with no acceptance (bubble).
REQ-016 SHALL hold all stages, valids, tags, beat count, and state unchanged while stall_i=1, except as in REQ-021.
REQ-017 SHALL give latency 1 cycle from acceptance to out_o1 and 3 cycles to out_o3/id_o.
REQ-018 SHALL implement two states: IDLE (gnt_o=0) and BUSY (gnt_o one-hot to owner).
REQ-019 SHALL arbitrate in IDLE when any req_i bit is 1: grant the first requester in order ptr, ptr+1, ptr+2 (mod 3), entering BUSY at the next edge.
REQ-020 SHALL count accepted beats in BUSY and release the owner at the edge that completes the MAX_BURST-th beat.
REQ-021 SHALL release the owner at the next edge when the owner's req_i is 0, including while stalled.
REQ-022 SHALL rearbitrate on release in the same edge, starting from owner+1; it grants the former owner only if no other requester is active.
REQ-023 SHALL go to IDLE on release when no req_i bit is 1.
REQ-024 SHALL set ptr to owner+1 mod 3 and clear the beat count on every release.
REQ-025 SHALL never assert more than one gnt_o bit, and SHALL never assert a gnt_o bit for a requester whose req_i was 0 at the arbitration edge.
REQ-026 SHALL ignore data_i for non-owners and for any cycle without acceptance.

Reset
REQ-027 SHALL, while reset_i=1 and independent of clk_i, force gnt_o=0, vld_o=0, id_o=0, out_o1..3=0, state IDLE, ptr=0, beat count 0.
REQ-028 SHALL discard in-flight beats when reset asserts mid-operation, with no partial output.
REQ-029 SHALL resume normal operation at the first rising edge after reset_i deasserts; requester 0 has first priority.

Verification
REQ-030 SHALL test a single requester: req_i=001, data 4'h5, MAX_BURST=2 -> gnt_o=001 one cycle later; beats 5,5 accepted; out_o1=5 one cycle after each; id_o=0 at stage 3; then release and regrant to 0.
REQ-031 SHALL test round robin: req_i=111 held -> grant sequence 001,010,100,001, each held exactly 2 accepted beats; id_o sequence at stage 3 is 0,0,1,1,2,2.
REQ-032 SHALL test stall: stall_i=1 for 3 cycles mid-burst -> out_o1..3, vld_o, gnt_o, and beat count frozen; the burst completes after stall_i=0 with no lost or duplicated beat.
REQ-033 SHALL test early drop: owner 1 drops req after 1 beat while req_i[2]=1 -> gnt_o=100 at the next edge; a bubble enters stage 1.
REQ-034 SHALL test mid-operation reset: assert reset_i between clock edges with all stages valid -> all outputs 0 immediately; after deassert with req_i=110, the first grant is 010.
